// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: queues 3x3 convolution jobs and launches them one at a time on the engine's
// run/busy handshake, reporting completion, start/run timeouts and a saturating completion count.
`default_nettype none

module conv_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int AW      = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [AW-1:0]            job_in_base,
  input  logic [AW-1:0]            job_out_base,
  input  logic [AW-1:0]            job_wgt_addr,
  input  logic                     abort,
  output logic                     eng_run,
  input  logic                     eng_busy,
  output logic [AW-1:0]            eng_in_base,
  output logic [AW-1:0]            eng_out_base,
  output logic [AW-1:0]            eng_wgt_addr,
  output logic                     job_done,
  output logic                     job_error,
  output logic [1:0]               err_code,
  output logic [7:0]               job_id,
  output logic [15:0]              jobs_completed,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     sched_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] fifo_in  [DEPTH];
  logic [AW-1:0] fifo_out [DEPTH];
  logic [AW-1:0] fifo_wgt [DEPTH];
  logic [7:0]    fifo_id  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    push_id;
  logic [1:0]    wb_cnt;
  logic [WW-1:0] wd_cnt;

  logic       push, pop, done_ev, err_ev;
  logic [1:0] err_nxt;

  // No full-FIFO bypass: a pop in the same cycle does not open a slot.
  assign job_ready  = (queue_count < CW'(DEPTH)) && !abort;
  assign push       = job_valid && job_ready;
  assign eng_run    = (state == S_LAUNCH);
  assign sched_busy = (state != S_IDLE) || (queue_count != '0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Abort takes priority over every completion or timeout event.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_ev   = 1'b0;
    err_ev    = 1'b0;
    err_nxt   = 2'b00;
    case (state)
      S_IDLE: begin
        if ((queue_count != '0) && !abort) begin
          state_nxt = S_LAUNCH;
          pop       = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_nxt = abort ? S_DRAIN : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (abort) begin
          state_nxt = S_DRAIN;
        end else if (eng_busy) begin
          state_nxt = S_RUN;
        end else if (wb_cnt == 2'd3) begin
          state_nxt = S_IDLE;
          err_ev    = 1'b1;
          err_nxt   = 2'b01;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_DRAIN;
        end else if (!eng_busy) begin
          state_nxt = S_IDLE;
          done_ev   = 1'b1;
        end else if (wd_cnt == WD_LIMIT) begin
          state_nxt = S_DRAIN;
          err_ev    = 1'b1;
          err_nxt   = 2'b10;
        end
      end
      S_DRAIN: begin
        if (!eng_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_in[wr_ptr]  <= job_in_base;
      fifo_out[wr_ptr] <= job_out_base;
      fifo_wgt[wr_ptr] <= job_wgt_addr;
      fifo_id[wr_ptr]  <= push_id;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      push_id     <= '0;
    end else begin
      if (push) push_id <= push_id + 8'd1;
      if (abort) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        queue_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      queue_count <= queue_count + 1'b1;
        else if (pop && !push) queue_count <= queue_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      eng_in_base    <= '0;
      eng_out_base   <= '0;
      eng_wgt_addr   <= '0;
      job_id         <= '0;
      job_done       <= 1'b0;
      job_error      <= 1'b0;
      err_code       <= 2'b00;
      jobs_completed <= '0;
      wb_cnt         <= '0;
      wd_cnt         <= '0;
    end else begin
      if (pop) begin
        eng_in_base  <= fifo_in[rd_ptr];
        eng_out_base <= fifo_out[rd_ptr];
        eng_wgt_addr <= fifo_wgt[rd_ptr];
        job_id       <= fifo_id[rd_ptr];
      end
      job_done  <= done_ev;
      job_error <= err_ev;
      err_code  <= err_nxt;
      if (done_ev && (jobs_completed != 16'hFFFF))
        jobs_completed <= jobs_completed + 16'd1;
      wb_cnt <= (state == S_WAIT_BUSY) ? wb_cnt + 2'd1 : 2'd0;
      // Watchdog reads 1 during the first RUN cycle.
      if (state == S_WAIT_BUSY && state_nxt == S_RUN) wd_cnt <= WW'(1);
      else if (state == S_RUN && state_nxt == S_RUN)  wd_cnt <= wd_cnt + 1'b1;
      else                                            wd_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_job_scheduler.sv
// Testbench for conv_job_scheduler: table-driven job list with a scoreboard, plus hand sequences
// for FIFO full, abort, abort-vs-completion and mid-job reset.
`default_nettype none

module tb_conv_job_scheduler;
  localparam int AW = 12;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [AW-1:0] job_in_base = '0;
  logic [AW-1:0] job_out_base = '0;
  logic [AW-1:0] job_wgt_addr = '0;
  logic          abort = 1'b0;
  logic          eng_run;
  logic          eng_busy = 1'b0;
  logic [AW-1:0] eng_in_base, eng_out_base, eng_wgt_addr;
  logic          job_done, job_error;
  logic [1:0]    err_code;
  logic [7:0]    job_id;
  logic [15:0]   jobs_completed;
  logic [2:0]    queue_count;
  logic          sched_busy;

  always #5 clk = ~clk;

  conv_job_scheduler #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready),
    .job_in_base(job_in_base), .job_out_base(job_out_base), .job_wgt_addr(job_wgt_addr),
    .abort(abort), .eng_run(eng_run), .eng_busy(eng_busy),
    .eng_in_base(eng_in_base), .eng_out_base(eng_out_base), .eng_wgt_addr(eng_wgt_addr),
    .job_done(job_done), .job_error(job_error), .err_code(err_code), .job_id(job_id),
    .jobs_completed(jobs_completed), .queue_count(queue_count), .sched_busy(sched_busy)
  );

  // mode 0: engine busy for len cycles; 1: engine never goes busy; 2: engine stuck busy
  typedef struct {
    logic [11:0] in_b;
    logic [11:0] out_b;
    logic [11:0] wgt;
    int          mode;
    int          len;
  } vec_t;

  typedef struct {
    logic [7:0]  id;
    int          vidx;
    logic [11:0] in_b;
    logic [11:0] out_b;
    logic [11:0] wgt;
  } sb_t;

  vec_t       vec [6];
  sb_t        sb [$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] next_id = 8'd0;
  int         exp_jc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (eng_run) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("eng_run wait", 32'(eng_run), 32'd1);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (job_done || job_error) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("pulse wait", 32'(job_done | job_error), 32'd1);
  endtask

  task automatic push_job(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                          input int vidx);
    sb_t e;
    bit  ok;
    ok = 1'b0;
    job_in_base  = a;
    job_out_base = b;
    job_wgt_addr = c;
    job_valid    = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (job_ready) begin
        @(posedge clk);
        e.id = next_id; e.vidx = vidx; e.in_b = a; e.out_b = b; e.wgt = c;
        sb.push_back(e);
        next_id = next_id + 8'd1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push accept", 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic check_launch(output sb_t e);
    e.id = 8'd0; e.vidx = 0; e.in_b = '0; e.out_b = '0; e.wgt = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL launch: got eng_run with no queued job expected none (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      chk("eng_in_base", 32'(eng_in_base), 32'(e.in_b));
      chk("eng_out_base", 32'(eng_out_base), 32'(e.out_b));
      chk("eng_wgt_addr", 32'(eng_wgt_addr), 32'(e.wgt));
      chk("launch job_id", 32'(job_id), 32'(e.id));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n, bad, gap;
    sb_t  e;
    logic [7:0] exp_id;

    vec[0] = '{12'h000, 12'h100, 12'h001, 0, 12};
    vec[1] = '{12'h010, 12'h200, 12'h002, 1, 0};
    vec[2] = '{12'h020, 12'h300, 12'h003, 0, 3};
    vec[3] = '{12'h030, 12'h400, 12'h004, 2, 0};
    vec[4] = '{12'hFFF, 12'hFFE, 12'hABC, 0, 2};
    vec[5] = '{12'h5A5, 12'h0A5, 12'h7FF, 1, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst eng_run", 32'(eng_run), 32'd0);
    chk("rst job_done", 32'(job_done), 32'd0);
    chk("rst job_error", 32'(job_error), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    chk("rst job_id", 32'(job_id), 32'd0);
    chk("rst jobs_completed", 32'(jobs_completed), 32'd0);
    chk("rst queue_count", 32'(queue_count), 32'd0);
    chk("rst sched_busy", 32'(sched_busy), 32'd0);
    chk("rst eng addrs", 32'({eng_in_base, eng_out_base, eng_wgt_addr} != '0), 32'd0);
    chk("rst job_ready", 32'(job_ready), 32'd1);
    reset_b = 1'b1;
    @(negedge clk);

    // Table phase: host pushes while the engine model serves launches
    fork
      begin
        for (int i = 0; i < 6; i++) push_job(vec[i].in_b, vec[i].out_b, vec[i].wgt, i);
      end
      begin
        gap = 0;
        for (int j = 0; j < 6; j++) begin
          int v;
          wait_run(n);
          if (n == 0) break;
          if (gap != 0) chk("launch gap", 32'(n), 32'(gap));
          check_launch(e);
          v = e.vidx;
          if (vec[v].mode == 0) begin
            eng_busy = 1'b1;
            repeat (vec[v].len) @(negedge clk);
            eng_busy = 1'b0;
            wait_pulse(n);
            chk("done latency", 32'(n), 32'd1);
          end else if (vec[v].mode == 1) begin
            wait_pulse(n);
            chk("start-timeout latency", 32'(n), 32'd5);
          end else begin
            eng_busy = 1'b1;
            wait_pulse(n);
            chk("run-timeout latency", 32'(n), 32'd18);
          end
          chk("job_done", 32'(job_done), 32'(vec[v].mode == 0));
          chk("job_error", 32'(job_error), 32'(vec[v].mode != 0));
          if (vec[v].mode != 0) chk("err_code", 32'(err_code), (vec[v].mode == 1) ? 32'd1 : 32'd2);
          chk("pulse job_id", 32'(job_id), 32'(e.id));
          if (vec[v].mode == 0) exp_jc++;
          chk("jobs_completed", 32'(jobs_completed), 32'(exp_jc));
          if (vec[v].mode == 2) begin
            bad = 0;
            repeat (3) begin
              @(negedge clk);
              if (eng_run || job_done || job_error) bad++;
            end
            chk("drain quiet", 32'(bad), 32'd0);
            chk("drain sched_busy", 32'(sched_busy), 32'd1);
            eng_busy = 1'b0;
            gap = (sb.size() != 0) ? 2 : 0;
          end else begin
            gap = (sb.size() != 0) ? 1 : 0;
          end
        end
      end
    join
    eng_busy = 1'b0;
    repeat (2) @(negedge clk);

    // FIFO full, then abort during RUN with the queue full
    push_job(12'h111, 12'h222, 12'h333, -1);
    wait_run(n);
    chk("push-to-start", 32'(n), 32'd1);
    check_launch(e);
    eng_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_job(12'(i), 12'(i + 16), 12'(i + 32), -1);
    chk("queue_count 3", 32'(queue_count), 32'd3);
    chk("job_ready at 3", 32'(job_ready), 32'd1);
    push_job(12'h0AA, 12'h0BB, 12'h0CC, -1);
    chk("queue_count full", 32'(queue_count), 32'd4);
    chk("job_ready full", 32'(job_ready), 32'd0);
    job_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("held push queue_count", 32'(queue_count), 32'd4);
    job_valid = 1'b0;
    abort = 1'b1;
    #1 chk("job_ready during abort", 32'(job_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    chk("abort queue_count", 32'(queue_count), 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (eng_run || job_done || job_error) bad++;
    end
    chk("abort quiet", 32'(bad), 32'd0);
    chk("abort drain sched_busy", 32'(sched_busy), 32'd1);
    eng_busy = 1'b0;
    @(negedge clk);
    chk("idle after abort", 32'(sched_busy), 32'd0);
    exp_id = next_id;
    push_job(12'h444, 12'h555, 12'h666, -1);
    wait_run(n);
    check_launch(e);
    chk("id after abort", 32'(job_id), 32'(exp_id));
    eng_busy = 1'b1;
    repeat (4) @(negedge clk);
    eng_busy = 1'b0;
    wait_pulse(n);
    chk("post-abort done", 32'(job_done), 32'd1);
    exp_jc++;
    chk("post-abort jobs_completed", 32'(jobs_completed), 32'(exp_jc));

    // Abort coinciding with busy falling in RUN
    push_job(12'h777, 12'h888, 12'h999, -1);
    wait_run(n);
    check_launch(e);
    eng_busy = 1'b1;
    repeat (5) @(negedge clk);
    eng_busy = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (job_done || job_error) bad++;
    end
    chk("abort vs done pulses", 32'(bad), 32'd0);
    chk("abort vs done count", 32'(jobs_completed), 32'(exp_jc));
    chk("abort vs done idle", 32'(sched_busy), 32'd0);

    // Reset asserted in LAUNCH
    push_job(12'h123, 12'h456, 12'h789, -1);
    wait_run(n);
    check_launch(e);
    #2 reset_b = 1'b0;
    #1;
    chk("async rst eng_run", 32'(eng_run), 32'd0);
    chk("async rst addrs", 32'({eng_in_base, eng_out_base, eng_wgt_addr} != '0), 32'd0);
    chk("async rst jobs_completed", 32'(jobs_completed), 32'd0);
    chk("async rst sched_busy", 32'(sched_busy), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    next_id = 8'd0;
    exp_jc = 0;
    sb.delete();
    push_job(12'h00F, 12'h0F0, 12'hF00, -1);
    wait_run(n);
    check_launch(e);
    eng_busy = 1'b1;
    repeat (2) @(negedge clk);
    eng_busy = 1'b0;
    wait_pulse(n);
    chk("after reset done id", 32'(job_id), 32'd0);
    chk("after reset jobs_completed", 32'(jobs_completed), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
